csr_file: RTL and testbench

Machine-mode CSR register file for the single-hart RV32 core. It supplies current CSR values to the CSR ALU and accepts the ALU's new-value writeback. It sequences trap entry (exception or external interrupt) and mret, and redirects fetch. It also maintains the 64-bit cycle and instret counters.

---
 rtl/csr_file.sv | 226 ++++++++++++++++++++++
 tb/tb_csr_file.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR register file for the single-hart RV32 core.
// Supplies CSR values to the CSR ALU and takes its writeback.
// Sequences trap entry (exception or external interrupt) and mret, and
// issues a one-cycle fetch redirect.
// Optional feature macro: CSR_COUNTERS_EN adds the 64-bit mcycle/minstret
// counters; without it the counter addresses read zero and ignore writes.
module csr_file #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] HART_ID     = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] csr_addr,
    output logic [31:0] csr_rdata,
    input  logic        csr_we,
    input  logic [31:0] csr_wdata,
    output logic        illegal_csr,
    input  logic [31:0] pc,
    input  logic        trap_req,
    input  logic [31:0] trap_cause,
    input  logic        mret,
    input  logic        irq_ext,
    input  logic        retire,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    localparam logic [31:0] MCAUSE_IRQ = 32'h8000_000B;
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_REDIR = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_nx_s;

    logic        mstatus_mie_r;
    logic        mstatus_mpie_r;
    logic        mie_meie_r;
    logic [31:0] mtvec_r;
    logic [31:0] mscratch_r;
    logic [31:0] mepc_r;
    logic [31:0] mcause_r;
    logic        redirect_valid_r;
    logic [31:0] redirect_pc_r;

    logic [31:0] rdata_s;
    logic        known_s;
    logic        illegal_s;
    logic        irq_pend_s;
    logic        take_trap_s;
    logic        take_irq_s;
    logic        take_mret_s;
    logic        event_s;
    logic        wr_en_s;
    logic [63:0] cycle_s;
    logic [63:0] instret_s;

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle_r;
    logic [63:0] minstret_r;

    assign cycle_s   = mcycle_r;
    assign instret_s = minstret_r;
`else
    logic        unused_retire_s;

    assign cycle_s         = 64'd0;
    assign instret_s       = 64'd0;
    assign unused_retire_s = retire;
`endif

    // CSR read selection with detection of unimplemented addresses
    always_comb begin
        rdata_s = 32'd0;
        known_s = 1'b1;
        case (csr_addr)
            12'h300: rdata_s = {19'd0, 2'b11, 3'd0, mstatus_mpie_r, 3'd0, mstatus_mie_r, 3'd0};
            12'h304: rdata_s = {20'd0, mie_meie_r, 11'd0};
            12'h305: rdata_s = mtvec_r;
            12'h340: rdata_s = mscratch_r;
            12'h341: rdata_s = mepc_r;
            12'h342: rdata_s = mcause_r;
            12'h344: rdata_s = {20'd0, irq_ext, 11'd0};
            12'hB00, 12'hC00: rdata_s = cycle_s[31:0];
            12'hB80, 12'hC80: rdata_s = cycle_s[63:32];
            12'hB02, 12'hC02: rdata_s = instret_s[31:0];
            12'hB82, 12'hC82: rdata_s = instret_s[63:32];
            12'hF14: rdata_s = HART_ID;
            default: begin
                rdata_s = 32'd0;
                known_s = 1'b0;
            end
        endcase
    end

    // Writes to the 0xC00-0xFFF block are read-only violations
    assign illegal_s   = ~known_s | (csr_we & (csr_addr[11:10] == 2'b11));
    assign csr_rdata   = rdata_s;
    assign illegal_csr = illegal_s;
    assign irq_pend_s  = irq_ext & mstatus_mie_r & mie_meie_r;

    // Event arbitration and next state: only RUN accepts events, trap first
    always_comb begin
        take_trap_s = 1'b0;
        take_irq_s  = 1'b0;
        take_mret_s = 1'b0;
        state_nx_s  = ST_RUN;
        case (state_r)
            ST_RUN: begin
                if (trap_req) begin
                    take_trap_s = 1'b1;
                end else if (irq_pend_s) begin
                    take_irq_s = 1'b1;
                end else if (mret) begin
                    take_mret_s = 1'b1;
                end else begin
                    take_trap_s = 1'b0;
                end
                if (take_trap_s | take_irq_s | take_mret_s) begin
                    state_nx_s = ST_REDIR;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_REDIR: state_nx_s = ST_RUN;
            default:  state_nx_s = ST_RUN;
        endcase
    end

    // A write coincident with an accepted event is dropped
    assign event_s = take_trap_s | take_irq_s | take_mret_s;
    assign wr_en_s = csr_we & ~illegal_s & ~event_s;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Redirect outputs: pulse the cycle after the accepting edge, target latched then
    always_ff @(posedge clk) begin
        if (reset) begin
            redirect_valid_r <= 1'b0;
            redirect_pc_r    <= 32'd0;
        end else begin
            redirect_valid_r <= event_s;
            if (take_trap_s | take_irq_s) begin
                redirect_pc_r <= mtvec_r;
            end else if (take_mret_s) begin
                redirect_pc_r <= mepc_r;
            end
        end
    end

    assign redirect_valid = redirect_valid_r;
    assign redirect_pc    = redirect_pc_r;

    // Architectural CSR state: trap entry, mret, then ALU writeback
    always_ff @(posedge clk) begin
        if (reset) begin
            mstatus_mie_r  <= 1'b0;
            mstatus_mpie_r <= 1'b0;
            mie_meie_r     <= 1'b0;
            mtvec_r        <= MTVEC_RESET & ALIGN_MASK;
            mscratch_r     <= 32'd0;
            mepc_r         <= 32'd0;
            mcause_r       <= 32'd0;
        end else if (take_trap_s | take_irq_s) begin
            mepc_r         <= pc & ALIGN_MASK;
            mcause_r       <= take_trap_s ? trap_cause : MCAUSE_IRQ;
            mstatus_mpie_r <= mstatus_mie_r;
            mstatus_mie_r  <= 1'b0;
        end else if (take_mret_s) begin
            mstatus_mie_r  <= mstatus_mpie_r;
            mstatus_mpie_r <= 1'b1;
        end else if (wr_en_s) begin
            case (csr_addr)
                12'h300: begin
                    mstatus_mie_r  <= csr_wdata[3];
                    mstatus_mpie_r <= csr_wdata[7];
                end
                12'h304: mie_meie_r <= csr_wdata[11];
                12'h305: mtvec_r    <= csr_wdata & ALIGN_MASK;
                12'h340: mscratch_r <= csr_wdata;
                12'h341: mepc_r     <= csr_wdata & ALIGN_MASK;
                12'h342: mcause_r   <= csr_wdata;
                default: mcause_r   <= mcause_r;
            endcase
        end
    end

`ifdef CSR_COUNTERS_EN
    // mcycle: counts every cycle; a half write replaces that half instead
    always_ff @(posedge clk) begin
        if (reset) begin
            mcycle_r <= 64'd0;
        end else if (wr_en_s && (csr_addr == 12'hB00)) begin
            mcycle_r <= {mcycle_r[63:32], csr_wdata};
        end else if (wr_en_s && (csr_addr == 12'hB80)) begin
            mcycle_r <= {csr_wdata, mcycle_r[31:0]};
        end else begin
            mcycle_r <= mcycle_r + 64'd1;
        end
    end

    // minstret: counts retirements; a half write replaces that half instead
    always_ff @(posedge clk) begin
        if (reset) begin
            minstret_r <= 64'd0;
        end else if (wr_en_s && (csr_addr == 12'hB02)) begin
            minstret_r <= {minstret_r[63:32], csr_wdata};
        end else if (wr_en_s && (csr_addr == 12'hB82)) begin
            minstret_r <= {csr_wdata, minstret_r[31:0]};
        end else if (retire) begin
            minstret_r <= minstret_r + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: self-checking bench for csr_file. Redirects are predicted
// into a scoreboard queue when an event is driven and compared when the
// DUT pulses redirect_valid; CSR reads are compared directly.
module tb_csr_file;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] csr_addr;
    logic [31:0] csr_rdata;
    logic        csr_we;
    logic [31:0] csr_wdata;
    logic        illegal_csr;
    logic [31:0] pc;
    logic        trap_req;
    logic [31:0] trap_cause;
    logic        mret;
    logic        irq_ext;
    logic        retire;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    typedef struct {
        int          cyc;
        logic [31:0] pc;
    } redir_t;

    redir_t sb[$];
    int     cyc      = 0;
    int     n_checks = 0;
    int     n_pass   = 0;

    csr_file #(
        .MTVEC_RESET(32'h0000_0203),
        .HART_ID    (32'd5)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .csr_addr      (csr_addr),
        .csr_rdata     (csr_rdata),
        .csr_we        (csr_we),
        .csr_wdata     (csr_wdata),
        .illegal_csr   (illegal_csr),
        .pc            (pc),
        .trap_req      (trap_req),
        .trap_cause    (trap_cause),
        .mret          (mret),
        .irq_ext       (irq_ext),
        .retire        (retire),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string tag);
        csr_addr = a;
        csr_we   = 1'b0;
        #1;
        check_eq(tag, csr_rdata, exp);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        csr_addr  = a;
        csr_wdata = d;
        csr_we    = 1'b1;
        tick();
        csr_we    = 1'b0;
    endtask

    task automatic expect_redir(input logic [31:0] target);
        redir_t e;
        e.cyc = cyc + 1;
        e.pc  = target;
        sb.push_back(e);
    endtask

    // Redirect monitor: expected pulses pop the scoreboard, any other pulse is an error
    always @(negedge clk) begin : mon
        redir_t e;
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            check_eq("redir_valid", {31'd0, redirect_valid}, 32'd1);
            check_eq("redir_pc", redirect_pc, e.pc);
        end else if (redirect_valid) begin
            check_eq("redir_spurious", {31'd0, redirect_valid}, 32'd0);
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; csr_addr = 12'd0; csr_we = 1'b0; csr_wdata = 32'd0;
        pc = 32'd0; trap_req = 1'b0; trap_cause = 32'd0; mret = 1'b0;
        irq_ext = 1'b0; retire = 1'b0;
        tick(); tick();
        reset = 1'b0;

        // Reset state
        check_eq("rst_redir_valid", {31'd0, redirect_valid}, 32'd0);
        check_eq("rst_redir_pc", redirect_pc, 32'd0);
        rd(12'h300, 32'h0000_1800, "rst_mstatus");
        check_eq("mstatus_legal", {31'd0, illegal_csr}, 32'd0);
        rd(12'h304, 32'd0, "rst_mie");
        rd(12'h305, 32'h0000_0200, "rst_mtvec");
        rd(12'h340, 32'd0, "rst_mscratch");
        rd(12'h341, 32'd0, "rst_mepc");
        rd(12'h342, 32'd0, "rst_mcause");
        rd(12'h344, 32'd0, "rst_mip");
        rd(12'hF14, 32'd5, "mhartid");
        rd(12'h7C0, 32'd0, "unimpl_rdata");
        check_eq("unimpl_illegal", {31'd0, illegal_csr}, 32'd1);

        // Exception entry
        wr(12'h305, 32'h0000_0103);
        rd(12'h305, 32'h0000_0100, "mtvec_wr");
        pc = 32'h0000_0040; trap_cause = 32'd11; trap_req = 1'b1;
        expect_redir(32'h0000_0100);
        tick();
        trap_req = 1'b0;
        rd(12'h341, 32'h0000_0040, "trap_mepc");
        rd(12'h342, 32'd11, "trap_mcause");
        rd(12'h300, 32'h0000_1800, "trap_mstatus");
        tick();

        // External interrupt entry then mret
        wr(12'h300, 32'h0000_0008);
        wr(12'h304, 32'h0000_0800);
        rd(12'h300, 32'h0000_1808, "mstatus_wr");
        rd(12'h304, 32'h0000_0800, "mie_wr");
        pc = 32'h0000_0082; irq_ext = 1'b1;
        expect_redir(32'h0000_0100);
        rd(12'h344, 32'h0000_0800, "mip_meip");
        tick();
        irq_ext = 1'b0;
        rd(12'h342, 32'h8000_000B, "irq_mcause");
        rd(12'h341, 32'h0000_0080, "irq_mepc");
        rd(12'h300, 32'h0000_1880, "irq_mstatus");
        tick();
        mret = 1'b1;
        expect_redir(32'h0000_0080);
        tick();
        mret = 1'b0;
        rd(12'h300, 32'h0000_1888, "mret_mstatus");
        tick();

        // trap_req + mret + csr_we together; trap_req again in REDIR; write in REDIR
        pc = 32'h0000_0200; trap_cause = 32'd2; trap_req = 1'b1; mret = 1'b1;
        csr_addr = 12'h340; csr_wdata = 32'h0000_DEAD; csr_we = 1'b1;
        expect_redir(32'h0000_0100);
        tick();
        mret = 1'b0; pc = 32'h0000_0300; trap_cause = 32'd7;
        rd(12'h340, 32'd0, "prio_we_dropped");
        csr_addr = 12'h340; csr_wdata = 32'h0000_1234; csr_we = 1'b1;
        tick();
        csr_we = 1'b0; trap_req = 1'b0;
        rd(12'h340, 32'h0000_1234, "redir_we_kept");
        rd(12'h342, 32'd2, "prio_mcause");
        rd(12'h341, 32'h0000_0200, "prio_mepc");
        rd(12'h300, 32'h0000_1880, "prio_mstatus");

        // Interrupt masked by MIE=0
        irq_ext = 1'b1;
        tick(); tick();
        irq_ext = 1'b0;
        rd(12'h342, 32'd2, "irq_masked_mcause");

        // Interrupt beats mret
        wr(12'h300, 32'h0000_0008);
        pc = 32'h0000_0104; irq_ext = 1'b1; mret = 1'b1;
        expect_redir(32'h0000_0100);
        tick();
        irq_ext = 1'b0; mret = 1'b0;
        rd(12'h342, 32'h8000_000B, "irq_vs_mret_mcause");
        rd(12'h341, 32'h0000_0104, "irq_vs_mret_mepc");
        rd(12'h300, 32'h0000_1880, "irq_vs_mret_mstatus");
        tick();

        // mret drops a coincident write
        mret = 1'b1; csr_addr = 12'h340; csr_wdata = 32'h0000_BEEF; csr_we = 1'b1;
        expect_redir(32'h0000_0104);
        tick();
        mret = 1'b0; csr_we = 1'b0;
        rd(12'h340, 32'h0000_1234, "mret_we_dropped");
        rd(12'h300, 32'h0000_1888, "mret2_mstatus");
        tick();

        // Illegal / ignored writes
        csr_addr = 12'hF14; csr_wdata = 32'd0; csr_we = 1'b1;
        #1 check_eq("we_hartid_illegal", {31'd0, illegal_csr}, 32'd1);
        tick();
        csr_we = 1'b0;
        rd(12'hF14, 32'd5, "hartid_kept");
        csr_addr = 12'h344; csr_wdata = 32'hFFFF_FFFF; csr_we = 1'b1;
        #1 check_eq("we_mip_legal", {31'd0, illegal_csr}, 32'd0);
        tick();
        csr_we = 1'b0;
        rd(12'h344, 32'd0, "mip_unchanged");
        csr_addr = 12'hC00; csr_wdata = 32'd0; csr_we = 1'b1;
        #1 check_eq("we_cycle_illegal", {31'd0, illegal_csr}, 32'd1);
        tick();
        csr_we = 1'b0;
        rd(12'hC02, 32'd0, "instret_idle");
        check_eq("rd_shadow_legal", {31'd0, illegal_csr}, 32'd0);

`ifdef CSR_COUNTERS_EN
        // Counters: retire counting, 64-bit wrap and carry
        rd(12'hB02, 32'd0, "minstret_idle");
        retire = 1'b1;
        tick(); tick(); tick();
        retire = 1'b0;
        rd(12'hB02, 32'd3, "minstret_count");
        rd(12'hC02, 32'd3, "instret_count");
        wr(12'hB00, 32'hFFFF_FFFF);
        wr(12'hB80, 32'hFFFF_FFFF);
        rd(12'hB00, 32'hFFFF_FFFF, "mcycle_lo_wr");
        rd(12'hB80, 32'hFFFF_FFFF, "mcycleh_wr");
        tick();
        rd(12'hB00, 32'd0, "mcycle_wrap_lo");
        rd(12'hB80, 32'd0, "mcycle_wrap_hi");
        rd(12'hC80, 32'd0, "cycleh_wrap");
        wr(12'hB00, 32'hFFFF_FFFF);
        tick();
        rd(12'hB80, 32'd1, "mcycle_carry_hi");
        rd(12'hB00, 32'd0, "mcycle_carry_lo");
        rd(12'hB82, 32'd0, "minstreth_idle");
`else
        // No counter hardware: reads zero, writes silently ignored
        rd(12'hB00, 32'd0, "mcycle_absent");
        check_eq("mcycle_rd_legal", {31'd0, illegal_csr}, 32'd0);
        csr_addr = 12'hB00; csr_wdata = 32'h0000_0055; csr_we = 1'b1;
        #1 check_eq("mcycle_we_legal", {31'd0, illegal_csr}, 32'd0);
        tick();
        csr_we = 1'b0;
        rd(12'hB00, 32'd0, "mcycle_absent_wr");
`endif

        // Reset during REDIR cancels the pulse and restores reset values
        wr(12'h340, 32'h0000_00AA);
        pc = 32'h0000_0400; trap_cause = 32'd3; trap_req = 1'b1;
        expect_redir(32'h0000_0100);
        tick();
        trap_req = 1'b0; reset = 1'b1;
        tick();
        check_eq("rst_redir_cancel", {31'd0, redirect_valid}, 32'd0);
        check_eq("rst_redir_pc_clr", redirect_pc, 32'd0);
        rd(12'h300, 32'h0000_1800, "rst2_mstatus");
        rd(12'h304, 32'd0, "rst2_mie");
        rd(12'h305, 32'h0000_0200, "rst2_mtvec");
        rd(12'h340, 32'd0, "rst2_mscratch");
        rd(12'h341, 32'd0, "rst2_mepc");
        rd(12'h342, 32'd0, "rst2_mcause");

        // Reset wins over a coincident trap
        trap_req = 1'b1;
        tick();
        trap_req = 1'b0; reset = 1'b0;
        tick(); tick();
        rd(12'h342, 32'd0, "rst_trap_mcause");

        check_eq("sb_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
